// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- load/use hazard and mispredict control for a short
// in-order pipeline (FE, ID, EX, MEM, WB).
//
// Tracks the destination register of the instructions in EX and MEM and
// stalls the ID instruction while either one is about to write a register
// that ID reads. WB is not tracked because the register file writes on the
// negative edge, so ID already sees the WB result. A mispredict resolved in
// EX flushes FE, bubbles ID->EX and masks the ID latch for one cycle. The
// mispredict takes priority over any stall.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-high; clears all state and forces the
//                control outputs low while high
//   id_valid     ID latch holds a real instruction
//   id_rs/id_rt  ID source specifiers; id_uses_rs/id_uses_rt qualify them
//   id_wr_reg    ID instruction writes id_wregno
//   ex_mispred   branch/JAL in EX resolved to a mispredict
//   cnt_clr      synchronous clear of stall_cnt / flush_cnt
//   stall_pipe   hold PC_FE and the FE latch; ID latch is not advanced
//   flush_fe     load a NOP (all zeros) into the FE latch
//   bubble_ex    load zero control signals into the ID->EX latch
//   state        current FSM state (RUN=0, STALL=1, FLUSH=2)
//   stall_cnt    saturating count of stall cycles
//   flush_cnt    saturating count of mispredicts
//   err_stuck    sticky: a stall lasted longer than any legal dependence

module pipe_hazard_ctrl #(
  parameter int REGNOBITS = 4,
  parameter int CNTBITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REGNOBITS-1:0] id_rs,
  input  logic [REGNOBITS-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_wr_reg,
  input  logic [REGNOBITS-1:0] id_wregno,
  input  logic                 ex_mispred,
  input  logic                 cnt_clr,
  output logic                 stall_pipe,
  output logic                 flush_fe,
  output logic                 bubble_ex,
  output logic [1:0]           state,
  output logic [CNTBITS-1:0]   stall_cnt,
  output logic [CNTBITS-1:0]   flush_cnt,
  output logic                 err_stuck
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [CNTBITS-1:0] CNT_MAX = '1;

  state_t cur_state, nxt_state;

  // In-flight writer slots. Kept as separate signals so each field can be
  // observed on its own.
  logic                 ex_v,  mem_v;
  logic [REGNOBITS-1:0] ex_r,  mem_r;

  logic [1:0] consec;  // consecutive stall cycles, saturating at 3

  logic id_eff, match_rs, match_rt, hazard;

  // Register 0 is compared like any other register: a writer of R0 still
  // creates a dependence here.
  assign match_rs = (ex_v && (ex_r == id_rs)) || (mem_v && (mem_r == id_rs));
  assign match_rt = (ex_v && (ex_r == id_rt)) || (mem_v && (mem_r == id_rt));

  // In FLUSH the ID latch holds the squashed NOP, whatever id_valid says.
  assign id_eff = id_valid && (cur_state != FLUSH);
  assign hazard = id_eff && ((id_uses_rs && match_rs) || (id_uses_rt && match_rt));

  // Gated by reset so that the pipeline is not held or flushed by stale
  // inputs while reset is asserted.
  assign stall_pipe = !reset && hazard && !ex_mispred;
  assign flush_fe   = !reset && ex_mispred;
  assign bubble_ex  = stall_pipe || flush_fe;

  assign state = cur_state;

  // ---------------------------------------------------------------- FSM
  // NOTE: state and all other registers use non-blocking assignments so
  // every flop samples values from before the edge, regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= RUN;
    else       cur_state <= nxt_state;
  end

  // FLUSH lasts exactly one cycle without a dedicated rule: in FLUSH id_eff
  // is 0, so hazard is 0 and only a new mispredict keeps the FSM there.
  // NOTE: nxt_state gets a default before any branch so no latch is inferred.
  always_comb begin
    nxt_state = RUN;
    if (ex_mispred)  nxt_state = FLUSH;
    else if (hazard) nxt_state = STALL;
  end

  // -------------------------------------------------------- writer slots
  // A bubbled instruction (stalled or squashed) never occupies EX, so the
  // dependence drains one stage per cycle while ID waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v  <= 1'b0;
      ex_r  <= '0;
      mem_v <= 1'b0;
      mem_r <= '0;
    end else begin
      ex_v  <= id_eff && id_wr_reg && !bubble_ex;
      ex_r  <= id_wregno;
      mem_v <= ex_v;
      mem_r <= ex_r;
    end
  end

  // ----------------------------------------------------- event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pipe && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (ex_mispred && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------ stuck monitor
  // The longest legal stall is 2 cycles (dependence on the EX writer), so a
  // 3rd consecutive stall cycle means the slots are not draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      consec    <= 2'd0;
      err_stuck <= 1'b0;
    end else begin
      if (!stall_pipe)          consec <= 2'd0;
      else if (consec != 2'd3)  consec <= consec + 2'd1;
      if (stall_pipe && (consec == 2'd2)) err_stuck <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled a further unit later, well before the
// next edge.

module tb_pipe_hazard_ctrl;

  localparam int REGNOBITS = 4;
  localparam int CNTBITS   = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 id_valid;
  logic [REGNOBITS-1:0] id_rs, id_rt, id_wregno;
  logic                 id_uses_rs, id_uses_rt, id_wr_reg;
  logic                 ex_mispred, cnt_clr;
  logic                 stall_pipe, flush_fe, bubble_ex, err_stuck;
  logic [1:0]           state;
  logic [CNTBITS-1:0]   stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGNOBITS(REGNOBITS), .CNTBITS(CNTBITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_wr_reg  (id_wr_reg),
    .id_wregno  (id_wregno),
    .ex_mispred (ex_mispred),
    .cnt_clr    (cnt_clr),
    .stall_pipe (stall_pipe),
    .flush_fe   (flush_fe),
    .bubble_ex  (bubble_ex),
    .state      (state),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .err_stuck  (err_stuck)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the ID latch contents.
  task automatic set_id(input logic v, input logic [3:0] rs, input logic urs,
                        input logic [3:0] rt, input logic urt,
                        input logic wr, input logic [3:0] wno);
    id_valid   = v;
    id_rs      = rs;
    id_uses_rs = urs;
    id_rt      = rt;
    id_uses_rt = urt;
    id_wr_reg  = wr;
    id_wregno  = wno;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------------------------------------------------- reset
    reset      = 1'b1;
    ex_mispred = 1'b1;   // must be masked while reset is high
    cnt_clr    = 1'b0;
    set_id(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3);
    tick();
    check("rst_stall",     stall_pipe, 0);
    check("rst_flush",     flush_fe,   0);
    check("rst_bubble",    bubble_ex,  0);
    check("rst_state",     state,      0);
    check("rst_stall_cnt", stall_cnt,  0);
    check("rst_flush_cnt", flush_cnt,  0);
    check("rst_err",       err_stuck,  0);
    reset      = 1'b0;
    ex_mispred = 1'b0;
    idle();
    tick();

    // ------------------- ADDI R3 ; ADD reads R3 -> 2-cycle stall
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b0, 1'b1, 4'd3);  // ADDI R3, R1
    check("addi_nostall", stall_pipe, 0);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b1, 4'd5);  // ADD R5, R3, R4
    check("raw1_stall",  stall_pipe, 1);
    check("raw1_bubble", bubble_ex,  1);
    check("raw1_state",  state,      0);
    tick();
    check("raw2_stall",  stall_pipe, 1);
    check("raw2_bubble", bubble_ex,  1);
    check("raw2_state",  state,      1);
    tick();
    check("raw3_stall",  stall_pipe, 0);
    check("raw3_bubble", bubble_ex,  0);
    check("raw3_state",  state,      1);
    tick();
    idle();
    check("raw4_state",     state,     0);
    check("raw_stall_cnt",  stall_cnt, 2);
    tick();
    tick();

    // ------------------------------------------ cnt_clr with no stall
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_stall_cnt", stall_cnt, 0);

    // ------------- R3 writer ; independent ; R3 reader -> 1-cycle stall
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3);
    tick();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd6);
    check("gap_indep", stall_pipe, 0);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
    check("gap_stall1", stall_pipe, 1);
    tick();
    check("gap_stall2", stall_pipe, 0);
    tick();
    idle();
    check("gap_stall_cnt", stall_cnt, 1);
    tick();
    tick();

    // -------------------------- mispredict coinciding with a hazard
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd7);  // reads R3, writes R7
    ex_mispred = 1'b1;
    #1;
    check("mp_stall",  stall_pipe, 0);
    check("mp_flush",  flush_fe,   1);
    check("mp_bubble", bubble_ex,  1);
    tick();
    ex_mispred = 1'b0;
    #1;
    check("mp_state_flush", state,     2);
    check("mp_squash_exs",  dut.ex_v,  0);
    check("mp_flush_cnt",   flush_cnt, 1);
    // R3 writer is now in MEM, but ID is masked in FLUSH.
    check("mp_masked",      stall_pipe, 0);
    check("mp_flush_off",   flush_fe,   0);
    tick();
    check("mp_state_run",   state,      0);
    set_id(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
    check("mp_no_r7_dep",   stall_pipe, 0);
    idle();
    tick();
    tick();

    // --------------------------------------- operand qualifiers
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3);
    tick();
    set_id(1'b1, 4'd1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0);
    check("rt_unused",     stall_pipe, 0);
    set_id(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
    check("id_invalid",    stall_pipe, 0);
    set_id(1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0);
    check("rt_used_stall", stall_pipe, 1);
    idle();
    tick();
    tick();

    // ------------- forced hazard: err_stuck, saturation, clear priority
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    force dut.ex_v = 1'b1;
    force dut.ex_r = 4'd3;
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
    check("frc_stall", stall_pipe, 1);
    tick();
    tick();
    check("frc_err_2cyc", err_stuck, 0);
    tick();
    check("frc_err_3cyc", err_stuck, 1);
    check("frc_cnt3",     stall_cnt, 3);
    repeat (65532) tick();
    check("sat_reach", stall_cnt, 16'hFFFF);
    tick();
    check("sat_hold",  stall_cnt, 16'hFFFF);
    check("sat_stall", stall_pipe, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_wins",  stall_cnt, 0);
    check("err_sticky", err_stuck, 1);
    release dut.ex_v;
    release dut.ex_r;
    idle();
    tick();
    tick();

    // ------------------------------------------------ reset mid-stall
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
    check("prerst_stall", stall_pipe, 1);
    reset      = 1'b1;
    ex_mispred = 1'b1;
    #1;
    check("midrst_stall",  stall_pipe, 0);
    check("midrst_flush",  flush_fe,   0);
    check("midrst_bubble", bubble_ex,  0);
    check("midrst_err",    err_stuck,  0);
    check("midrst_state",  state,      0);
    tick();
    reset      = 1'b0;
    ex_mispred = 1'b0;
    #1;
    check("postrst_nohaz", stall_pipe, 0);
    check("postrst_cnt",   stall_cnt,  0);
    check("postrst_fcnt",  flush_cnt,  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REGNOBITS, default 4, width of register specifiers.
REQ-002 SHALL have parameter CNTBITS, default 16, width of the event counters.
REQ-003 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high; all state is cleared while it is high.
REQ-005 SHALL have port id_valid, input, 1: the ID latch holds a real instruction.
REQ-006 SHALL have ports id_rs and id_rt, input, REGNOBITS: the ID source specifiers.
REQ-007 SHALL have ports id_uses_rs and id_uses_rt, input, 1: the ID instruction reads rs / rt.
REQ-008 SHALL have port id_wr_reg, input, 1: the ID instruction writes a register.
REQ-009 SHALL have port id_wregno, input, REGNOBITS: the ID destination specifier.
REQ-010 SHALL have port ex_mispred, input, 1: the branch/JAL now in EX resolved to a mispredict.
REQ-011 SHALL have port cnt_clr, input, 1: synchronous clear of the counters.
REQ-012 SHALL have port stall_pipe, output, 1: hold PC_FE and the FE latch; the ID latch is not advanced.
REQ-013 SHALL have port flush_fe, output, 1: load NOP (all zeros) into the FE latch.
REQ-014 SHALL have port bubble_ex, output, 1: load zero control signals into the ID->EX latch.
REQ-015 SHALL have port state, output, 2: current FSM state (RUN=0, STALL=1, FLUSH=2).
REQ-016 SHALL have port stall_cnt, output, CNTBITS: saturating count of stall cycles.
REQ-017 SHALL have port flush_cnt, output, CNTBITS: saturating count of mispredicts.
REQ-018 SHALL have port err_stuck, output, 1: sticky flag set when a stall lasts too long.

Function
REQ-019 SHALL track two in-flight writer slots, EXs and MEMs, each holding a valid bit and a REGNOBITS specifier; the WB stage is not tracked because the register file writes on the negative edge.
REQ-020 SHALL compute match(r) = (EXs.v and EXs.r==r) or (MEMs.v and MEMs.r==r); register 0 is compared like any other register.
REQ-021 SHALL compute id_eff = id_valid and state!=FLUSH.
REQ-022 SHALL compute hazard = id_eff and ((id_uses_rs and match(id_rs)) or (id_uses_rt and match(id_rt))).
REQ-023 SHALL drive stall_pipe = hazard and not ex_mispred, combinationally in the same cycle.
REQ-024 SHALL drive flush_fe = ex_mispred.
REQ-025 SHALL drive bubble_ex = stall_pipe or ex_mispred.
REQ-026 SHALL update the slots on each clk edge: EXs <= {id_eff and id_wr_reg and not bubble_ex, id_wregno}; MEMs <= EXs.
REQ-027 SHALL make FSM transitions a priority over inputs: ex_mispred -> FLUSH from any state; else hazard -> STALL; else -> RUN.
REQ-028 SHALL leave FLUSH after exactly one cycle, since the ID latch then holds the flushed NOP.
REQ-029 SHALL ensure a mispredict coinciding with a hazard produces no stall, and that ex_mispred wins.
REQ-030 SHALL increment stall_cnt on each cycle with stall_pipe=1, saturating at all-ones.
REQ-031 SHALL increment flush_cnt on each cycle with ex_mispred=1, saturating at all-ones.
REQ-032 SHALL give cnt_clr priority over increment on the same edge.
REQ-033 SHALL keep a 2-bit consecutive-stall counter; err_stuck is set when stall_pipe stays high for a 3rd consecutive cycle, and is cleared only by reset.
REQ-034 SHALL make the maximum legitimate stall 2 cycles, i.e. a dependence on the EX writer.

Reset
REQ-035 SHALL on reset: state=RUN; both slots invalid with specifier 0; stall_cnt=0; flush_cnt=0; err_stuck=0; consecutive-stall counter 0.
REQ-036 SHALL force stall_pipe, flush_fe and bubble_ex to 0 while reset is high, regardless of inputs.
REQ-037 SHALL, on reset asserted mid-stall or mid-flush, drop all pending dependences; the first post-reset cycle sees no hazard.

Verification
REQ-038 SHALL cover: ADDI writing R3, then ADD reading R3 next cycle -> stall_pipe=1 for 2 cycles, bubble_ex=1 for 2 cycles, state RUN->STALL->STALL->RUN, stall_cnt=2.
REQ-039 SHALL cover: R3 writer, one independent instruction, then an R3 reader -> stall_pipe=1 for exactly 1 cycle, stall_cnt=1.
REQ-040 SHALL cover: ex_mispred=1 while ID has an R3 hazard -> stall_pipe=0, flush_fe=1, bubble_ex=1, next state FLUSH, then RUN; flush_cnt=1; the squashed ID writer does not occupy EXs.
REQ-041 SHALL cover: id_uses_rt=0 with id_rt matching EXs -> no stall; id_valid=0 with matching rs -> no stall.
REQ-042 SHALL cover: stall_cnt preset to 0xFFFF by repeated stalls, then one more stall -> stays 0xFFFF; cnt_clr with a concurrent stall -> 0.
REQ-043 SHALL cover: id_valid and hazard forced high for 3 cycles by holding the slots (force) -> err_stuck=1 from the 3rd cycle; reset pulse mid-stall -> all outputs 0 and err_stuck=0.
